// File: rtl/one_to_sixteen_deserializer.sv
// Serial-to-parallel receiver: one bit per valid cycle, LSB first, into a WIDTH-bit word.
// A completed word is registered together with a one-cycle word_valid strobe.
module one_to_sixteen_deserializer #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned SEL_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             din,
  input  logic             din_valid,
  input  logic             sof,
  output logic [WIDTH-1:0] word,
  output logic             word_valid,
  output logic [SEL_W-1:0] slot,
  output logic             busy,
  output logic             frame_err
);

  localparam logic [SEL_W-1:0] LAST_SLOT = SEL_W'(WIDTH - 1);

  logic [SEL_W-1:0] slot_q,   slot_d;
  logic [WIDTH-1:0] shadow_q, shadow_d;
  logic [WIDTH-1:0] word_q,   word_d;
  logic             word_valid_q, word_valid_d;
  logic             frame_err_q,  frame_err_d;

  always_comb begin
    slot_d       = slot_q;
    shadow_d     = shadow_q;
    word_d       = word_q;
    word_valid_d = 1'b0;
    frame_err_d  = 1'b0;
    if (din_valid) begin
      if (sof) begin
        // sof discards any partial frame and takes this bit as slot 0
        shadow_d    = '0;
        shadow_d[0] = din;
        slot_d      = SEL_W'(1);
        frame_err_d = (slot_q != '0);
      end else begin
        shadow_d[slot_q] = din;
        if (slot_q == LAST_SLOT) begin
          word_d       = {din, shadow_q[WIDTH-2:0]};
          word_valid_d = 1'b1;
          slot_d       = '0;
        end else begin
          slot_d = slot_q + SEL_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_q       <= '0;
      shadow_q     <= '0;
      word_q       <= '0;
      word_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      slot_q       <= slot_d;
      shadow_q     <= shadow_d;
      word_q       <= word_d;
      word_valid_q <= word_valid_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign word       = word_q;
  assign word_valid = word_valid_q;
  assign slot       = slot_q;
  assign busy       = (slot_q != '0);
  assign frame_err  = frame_err_q;

endmodule
